// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS core: opcodes, aluop codes, control states.
package mips_pkg;

    localparam int unsigned OPW    = 6;
    localparam int unsigned ALUOPW = 3;
    localparam int unsigned STW    = 4;

    localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPW-1:0] OP_LW    = 6'b100011;
    localparam logic [OPW-1:0] OP_SW    = 6'b101011;
    localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPW-1:0] OP_BNE   = 6'b000101;
    localparam logic [OPW-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPW-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OPW-1:0] OP_ORI   = 6'b001101;
    localparam logic [OPW-1:0] OP_SLTI  = 6'b001010;
    localparam logic [OPW-1:0] OP_J     = 6'b000010;

    localparam logic [ALUOPW-1:0] ALUOP_ADD   = 3'b000;
    localparam logic [ALUOPW-1:0] ALUOP_SUB   = 3'b001;
    localparam logic [ALUOPW-1:0] ALUOP_AND   = 3'b010;
    localparam logic [ALUOPW-1:0] ALUOP_OR    = 3'b011;
    localparam logic [ALUOPW-1:0] ALUOP_SLT   = 3'b100;
    localparam logic [ALUOPW-1:0] ALUOP_FUNCT = 3'b111;

    typedef enum logic [STW-1:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BRANCH  = 4'd8,
        IMMEX   = 4'd9,
        IMMWB   = 4'd10,
        JUMP    = 4'd11
    } state_t;

    // Control word driven by the output decoder.
    typedef struct packed {
        logic              iord;
        logic              irwrite;
        logic              memwrite;
        logic              regwrite;
        logic              regdst;
        logic              memtoreg;
        logic              alusrca;
        logic [1:0]        alusrcb;
        logic              zeroext;
        logic [ALUOPW-1:0] aluop;
        logic [1:0]        pcsrc;
        logic              pcen;
        logic              illegal;
    } ctrl_t;

    // State following DECODE for a given opcode; FETCH marks an unsupported opcode.
    function automatic state_t decode_next(input logic [OPW-1:0] op);
        state_t ns;
        ns = FETCH;
        case (op)
            OP_LW, OP_SW:                       ns = MEMADR;
            OP_RTYPE:                           ns = RTYPEEX;
            OP_BEQ, OP_BNE:                     ns = BRANCH;
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:  ns = IMMEX;
            OP_J:                               ns = JUMP;
            default:                            ns = FETCH;
        endcase
        return ns;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_outdec.sv
// Combinational state/op -> control-word decode for the multicycle controller.
module multicycle_ctrl_outdec
    import mips_pkg::*;
(
    input  state_t         state,
    input  logic [OPW-1:0] op,
    input  logic           zero,
    input  logic           memready,
    output ctrl_t          ctrl
);

    // Control word per state; anything not set stays 0.
    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.alusrcb = 2'b01;
                ctrl.aluop   = ALUOP_ADD;
                ctrl.irwrite = memready;
                ctrl.pcen    = memready;
            end
            DECODE: begin
                ctrl.alusrcb = 2'b11;
                ctrl.aluop   = ALUOP_ADD;
                ctrl.illegal = (decode_next(op) == FETCH);
            end
            MEMADR: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = 2'b10;
                ctrl.aluop   = ALUOP_ADD;
            end
            MEMRD: begin
                ctrl.iord = 1'b1;
            end
            MEMWB: begin
                ctrl.memtoreg = 1'b1;
                ctrl.regwrite = 1'b1;
            end
            MEMWR: begin
                ctrl.iord     = 1'b1;
                ctrl.memwrite = 1'b1;
            end
            RTYPEEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = 2'b00;
                ctrl.aluop   = ALUOP_FUNCT;
            end
            RTYPEWB: begin
                ctrl.regdst   = 1'b1;
                ctrl.regwrite = 1'b1;
            end
            BRANCH: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = 2'b00;
                ctrl.aluop   = ALUOP_SUB;
                ctrl.pcsrc   = 2'b01;
                ctrl.pcen    = (op == OP_BNE) ? ~zero : zero;
            end
            IMMEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = 2'b10;
                case (op)
                    OP_ANDI: begin
                        ctrl.aluop   = ALUOP_AND;
                        ctrl.zeroext = 1'b1;
                    end
                    OP_ORI: begin
                        ctrl.aluop   = ALUOP_OR;
                        ctrl.zeroext = 1'b1;
                    end
                    OP_SLTI: ctrl.aluop = ALUOP_SLT;
                    default: ctrl.aluop = ALUOP_ADD;
                endcase
            end
            IMMWB: begin
                ctrl.regwrite = 1'b1;
            end
            JUMP: begin
                ctrl.pcsrc = 2'b10;
                ctrl.pcen  = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS core: state register and next-state logic.
module multicycle_ctrl
    import mips_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [OPW-1:0]      op,
    input  logic                zero,
    input  logic                memready,
    output logic                iord,
    output logic                irwrite,
    output logic                memwrite,
    output logic                regwrite,
    output logic                regdst,
    output logic                memtoreg,
    output logic                alusrca,
    output logic [1:0]          alusrcb,
    output logic                zeroext,
    output logic [ALUOPW-1:0]   aluop,
    output logic [1:0]          pcsrc,
    output logic                pcen,
    output logic                illegal,
    output logic [STW-1:0]      dbg_state
);

    state_t state;
    state_t state_next;
    ctrl_t  ctrl;

    // State register; reset abandons any in-flight instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; memory states wait on memready.
    always_comb begin
        state_next = state;
        case (state)
            FETCH:   if (memready) state_next = DECODE;
            DECODE:  state_next = decode_next(op);
            MEMADR:  state_next = (op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   if (memready) state_next = MEMWB;
            MEMWB:   state_next = FETCH;
            MEMWR:   if (memready) state_next = FETCH;
            RTYPEEX: state_next = RTYPEWB;
            RTYPEWB: state_next = FETCH;
            BRANCH:  state_next = FETCH;
            IMMEX:   state_next = IMMWB;
            IMMWB:   state_next = FETCH;
            JUMP:    state_next = FETCH;
            default: state_next = FETCH;
        endcase
    end

    multicycle_ctrl_outdec u_outdec (
        .state    (state),
        .op       (op),
        .zero     (zero),
        .memready (memready),
        .ctrl     (ctrl)
    );

    assign iord      = ctrl.iord;
    assign irwrite   = ctrl.irwrite;
    assign memwrite  = ctrl.memwrite;
    assign regwrite  = ctrl.regwrite;
    assign regdst    = ctrl.regdst;
    assign memtoreg  = ctrl.memtoreg;
    assign alusrca   = ctrl.alusrca;
    assign alusrcb   = ctrl.alusrcb;
    assign zeroext   = ctrl.zeroext;
    assign aluop     = ctrl.aluop;
    assign pcsrc     = ctrl.pcsrc;
    assign pcen      = ctrl.pcen;
    assign illegal   = ctrl.illegal;
    assign dbg_state = STW'(state);

endmodule
